otter_pipe_ctrl: RTL

- Central hazard and sequencing controller for the 5-stage pipelined OTTER (IF, DE, EX, MEM, WB).
- Generates PC/IF-DE write enables and bubble/flush controls for data hazards and for branch/jump redirects resolved in EX.
- Owns the interrupt entry FSM: drains the pipe, then redirects to mtvec with a precise resume PC.
- Replaces the old multicycle CU FSM's sequencing role.

---
 rtl/otter_pipe_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/otter_pipe_ctrl.sv
// Hazard, redirect and interrupt-entry sequencing for the 5-stage OTTER pipeline.
// Optional macro OTTER_FWD_EN adds forwarding selects and reduces the interlock to load-use.
module otter_pipe_ctrl #(
    parameter int DRAIN_CYCLES     = 3,
    parameter bit RF_WRITE_THROUGH = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  de_rs1_addr,
    input  logic [4:0]  de_rs2_addr,
    input  logic        de_rs1_used,
    input  logic        de_rs2_used,
    input  logic [4:0]  ex_rd_addr,
    input  logic [4:0]  mem_rd_addr,
    input  logic [4:0]  wb_rd_addr,
    input  logic        ex_regWrite,
    input  logic        mem_regWrite,
    input  logic        wb_regWrite,
    input  logic        ex_memRead2,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] if_pc,
    input  logic [31:0] de_pc,
    input  logic        de_valid,
    input  logic        INTR,
    input  logic        mie,
    output logic        pc_write,
    output logic        if_de_write,
    output logic        if_de_flush,
    output logic        de_ex_flush,
    output logic        int_taken,
    output logic [31:0] mepc_out,
    output logic        stall
`ifdef OTTER_FWD_EN
    ,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic       WB_INTERLOCK = RF_WRITE_THROUGH ? 1'b0 : 1'b1;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_int_pending;
    logic [31:0] r_resume_pc;

    logic [4:0]  w_rd [3];
    logic [2:0]  w_we;
    logic [2:0]  w_match;
    logic        w_hazard;
    logic        w_int_req;
    logic        w_enter;

    // Stage order: 0 = EX, 1 = MEM, 2 = WB.
    assign w_rd[0] = ex_rd_addr;
    assign w_rd[1] = mem_rd_addr;
    assign w_rd[2] = wb_rd_addr;
    assign w_we    = {wb_regWrite, mem_regWrite, ex_regWrite};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_match
            assign w_match[gi] = w_we[gi] & (w_rd[gi] != 5'd0) &
                                 ((de_rs1_used & (de_rs1_addr == w_rd[gi])) |
                                  (de_rs2_used & (de_rs2_addr == w_rd[gi])));
        end
    endgenerate

`ifdef OTTER_FWD_EN
    assign w_hazard = de_valid & ex_memRead2 & w_match[0];

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (mem_regWrite && mem_rd_addr != 5'd0 && mem_rd_addr == de_rs1_addr)
            fwd_a_sel = 2'd1;
        else if (wb_regWrite && wb_rd_addr != 5'd0 && wb_rd_addr == de_rs1_addr)
            fwd_a_sel = 2'd2;
        if (mem_regWrite && mem_rd_addr != 5'd0 && mem_rd_addr == de_rs2_addr)
            fwd_b_sel = 2'd1;
        else if (wb_regWrite && wb_rd_addr != 5'd0 && wb_rd_addr == de_rs2_addr)
            fwd_b_sel = 2'd2;
    end
`else
    logic w_unused_load;
    assign w_unused_load = ex_memRead2;
    assign w_hazard = de_valid & (w_match[0] | w_match[1] | (w_match[2] & WB_INTERLOCK));
`endif

    // A request arriving this cycle may start draining immediately, giving DRAIN_CYCLES+1 latency.
    assign w_int_req = r_int_pending | (INTR & mie);
    assign w_enter   = (r_state == RUN) & w_int_req & ~redirect & ~w_hazard;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= RUN;
            r_cnt         <= 3'd0;
            r_int_pending <= 1'b0;
            r_resume_pc   <= 32'd0;
        end else begin
            if (r_state == TRAP)
                r_int_pending <= 1'b0;
            else if (INTR && mie)
                r_int_pending <= 1'b1;

            case (r_state)
                RUN: begin
                    if (w_enter) begin
                        r_state     <= DRAIN;
                        r_cnt       <= CNT_INIT;
                        r_resume_pc <= de_valid ? de_pc : if_pc;
                    end
                end
                DRAIN: begin
                    // An older branch/jump still in EX decides where the program resumes.
                    if (redirect && r_cnt == CNT_INIT)
                        r_resume_pc <= redirect_pc;
                    if (r_cnt == 3'd0)
                        r_state <= TRAP;
                    else
                        r_cnt <= r_cnt - 3'd1;
                end
                TRAP: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_de_write = 1'b1;
        if_de_flush = 1'b0;
        de_ex_flush = 1'b0;
        int_taken   = 1'b0;
        stall       = 1'b0;
        if (RESET) begin
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect) begin
                        if_de_flush = 1'b1;
                        de_ex_flush = 1'b1;
                    end else if (w_hazard) begin
                        pc_write    = 1'b0;
                        if_de_write = 1'b0;
                        de_ex_flush = 1'b1;
                        stall       = 1'b1;
                    end else if (w_int_req) begin
                        pc_write    = 1'b0;
                        if_de_flush = 1'b1;
                        de_ex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_write    = 1'b0;
                    if_de_flush = 1'b1;
                    de_ex_flush = 1'b1;
                end
                TRAP: begin
                    int_taken   = 1'b1;
                    if_de_flush = 1'b1;
                    de_ex_flush = 1'b1;
                end
                default: begin
                    if_de_flush = 1'b1;
                    de_ex_flush = 1'b1;
                end
            endcase
        end
    end

    assign mepc_out = r_resume_pc;

endmodule
